// File: rtl/bcd_counter_pkg.sv
// rtl/bcd_counter_pkg.sv - shared constants for the multi-digit BCD counter
package bcd_counter_pkg;
   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;
   localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit register with clear/load/step and propagate flag
module bcd_digit_cell
   import bcd_counter_pkg::*;
(
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               step_in,
   input  logic               dir_in,
   input  logic               load_in,
   input  logic [DIGIT_W-1:0] load_value_in,
   input  logic               clear_in,
   output logic [DIGIT_W-1:0] digit_out,
   output logic               prop_out,
   output logic               load_bad_out
);

   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;

   assign load_bad_out = (load_value_in > BCD_MAX);
   // Propagate reflects the current value only, so the top can chain it without loops.
   assign prop_out     = dir_in ? (digit_q == BCD_MAX) : (digit_q == BCD_ZERO);
   assign digit_out    = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (clear_in) begin
         digit_d = BCD_ZERO;
      end else if (load_in) begin
         digit_d = load_bad_out ? BCD_ZERO : load_value_in;
      end else if (step_in) begin
         if (dir_in) begin
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
         end else begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         digit_q <= BCD_ZERO;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD to active-low 7-segment pattern, bit 0 = a .. bit 6 = g
module seg7_decoder
   import bcd_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [SEG_W-1:0]   seg_out
);

   always_comb begin
      seg_out = 7'h7F;
      case (digit_in)
         4'd0: seg_out = 7'h40;
         4'd1: seg_out = 7'h79;
         4'd2: seg_out = 7'h24;
         4'd3: seg_out = 7'h30;
         4'd4: seg_out = 7'h19;
         4'd5: seg_out = 7'h12;
         4'd6: seg_out = 7'h02;
         4'd7: seg_out = 7'h78;
         4'd8: seg_out = 7'h00;
         4'd9: seg_out = 7'h10;
         default: seg_out = 7'h7F;
      endcase
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// rtl/bcd_counter_multi.sv - N-digit BCD up/down counter with load, clear, wrap/saturate and 7-seg bus
module bcd_counter_multi
   import bcd_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int WRAP_EN    = 1,
   parameter int SEG_EN     = 1
) (
   input  logic                          clk_in,
   input  logic                          reset_in,
   input  logic                          count_en_in,
   input  logic                          up_down_in,
   input  logic                          load_in,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value_in,
   input  logic                          clear_in,
   output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
   output logic [SEG_W*NUM_DIGITS-1:0]   seg_out,
   output logic                          tc_out,
   output logic                          load_err_out
);

   logic [NUM_DIGITS-1:0] prop;
   logic [NUM_DIGITS-1:0] load_bad;
   logic [NUM_DIGITS:0]   chain;
   logic                  sat_hold;
   logic                  upper_prop;
   logic                  reach_end;
   logic                  step_req;
   logic                  tc_d, tc_q;
   logic                  load_err_d, load_err_q;

   assign chain[0] = 1'b1;
   // In saturate mode a step at the range end is simply dropped.
   assign sat_hold = (WRAP_EN == 0) && chain[NUM_DIGITS];
   assign step_req = count_en_in && !clear_in && !load_in;

   generate
      for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
         assign chain[k+1] = chain[k] & prop[k];

         bcd_digit_cell u_cell (
            .clk_in        (clk_in),
            .reset_in      (reset_in),
            .step_in       (count_en_in && chain[k] && !sat_hold),
            .dir_in        (up_down_in),
            .load_in       (load_in),
            .load_value_in (load_value_in[DIGIT_W*k +: DIGIT_W]),
            .clear_in      (clear_in),
            .digit_out     (bcd_out[DIGIT_W*k +: DIGIT_W]),
            .prop_out      (prop[k]),
            .load_bad_out  (load_bad[k])
         );

         if (SEG_EN != 0) begin : g_seg
            seg7_decoder u_seg (
               .digit_in (bcd_out[DIGIT_W*k +: DIGIT_W]),
               .seg_out  (seg_out[SEG_W*k +: SEG_W])
            );
         end else begin : g_noseg
            assign seg_out[SEG_W*k +: SEG_W] = '1;
         end
      end
   endgenerate

   // Reaching an end: ones digit one step away and every higher digit already at the end.
   always_comb begin
      upper_prop = 1'b1;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         upper_prop = upper_prop & prop[k];
      end
      reach_end = upper_prop &&
                  (up_down_in ? (bcd_out[DIGIT_W-1:0] == 4'd8) : (bcd_out[DIGIT_W-1:0] == 4'd1));
   end

   always_comb begin
      tc_d       = 1'b0;
      load_err_d = 1'b0;
      if (clear_in) begin
         tc_d = 1'b0;
      end else if (load_in) begin
         load_err_d = |load_bad;
      end else if (step_req) begin
         if (WRAP_EN != 0) begin
            tc_d = chain[NUM_DIGITS];
         end else begin
            tc_d = !chain[NUM_DIGITS] && reach_end;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign tc_out       = tc_q;
   assign load_err_out = load_err_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb/tb_bcd_counter_multi.sv - self-checking bench for bcd_counter_multi (wrap and saturate instances)
module tb_bcd_counter_multi;

   localparam int ND  = 4;
   localparam int MAX = 9999;

   logic          clk = 1'b0;
   logic          rst, en, up, ld, clr;
   logic [15:0]   lv;
   logic [15:0]   bcd_w, bcd_s;
   logic [27:0]   seg_w, seg_s;
   logic          tc_w, tc_s, err_w, err_s;

   int nchecks = 0;
   int nerr    = 0;
   int mw = 0, ms = 0;
   logic mtw = 0, mts = 0, mew = 0, mes = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clk = ~clk;

   bcd_counter_multi #(.NUM_DIGITS(ND), .WRAP_EN(1), .SEG_EN(1)) dut_w (
      .clk_in(clk), .reset_in(rst), .count_en_in(en), .up_down_in(up),
      .load_in(ld), .load_value_in(lv), .clear_in(clr),
      .bcd_out(bcd_w), .seg_out(seg_w), .tc_out(tc_w), .load_err_out(err_w));

   bcd_counter_multi #(.NUM_DIGITS(ND), .WRAP_EN(0), .SEG_EN(1)) dut_s (
      .clk_in(clk), .reset_in(rst), .count_en_in(en), .up_down_in(up),
      .load_in(ld), .load_value_in(lv), .clear_in(clr),
      .bcd_out(bcd_s), .seg_out(seg_s), .tc_out(tc_s), .load_err_out(err_s));

   function automatic logic [15:0] to_bcd(int v);
      logic [15:0] r = '0;
      for (int k = 0; k < ND; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [27:0] seg_of(int v);
      logic [27:0] r = '0;
      for (int k = 0; k < ND; k++) begin
         r[7*k +: 7] = seg_tab[v % 10];
         v = v / 10;
      end
      return r;
   endfunction

   // Arithmetic model of one clock edge.
   task automatic model_step(input bit wrap, inout int v, output logic tc, output logic err);
      int f, pw, nv;
      tc = 0; err = 0;
      if (rst || clr) begin
         v = 0;
      end else if (ld) begin
         nv = 0; pw = 1;
         for (int k = 0; k < ND; k++) begin
            f = int'(lv[4*k +: 4]);
            if (f > 9) begin f = 0; err = 1; end
            nv += f * pw;
            pw *= 10;
         end
         v = nv;
      end else if (en) begin
         if (up) begin
            if (v == MAX) begin
               if (wrap) begin v = 0; tc = 1; end
            end else begin
               v = v + 1;
               tc = !wrap && (v == MAX);
            end
         end else begin
            if (v == 0) begin
               if (wrap) begin v = MAX; tc = 1; end
            end else begin
               v = v - 1;
               tc = !wrap && (v == 0);
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic c, input logic l, input logic [15:0] v,
                       input logic e, input logic u);
      rst = r; clr = c; ld = l; lv = v; en = e; up = u;
      model_step(1'b1, mw, mtw, mew);
      model_step(1'b0, ms, mts, mes);
      @(posedge clk);
      #1;
      check("w_bcd", 32'(bcd_w), 32'(to_bcd(mw)));
      check("w_tc",  32'(tc_w),  32'(mtw));
      check("w_err", 32'(err_w), 32'(mew));
      check("w_seg", 32'(seg_w), 32'(seg_of(mw)));
      check("s_bcd", 32'(bcd_s), 32'(to_bcd(ms)));
      check("s_tc",  32'(tc_s),  32'(mts));
      check("s_err", 32'(err_s), 32'(mes));
      check("s_seg", 32'(seg_s), 32'(seg_of(ms)));
   endtask

   typedef struct {
      logic        r, c, l, e, u;
      logic [15:0] v;
      logic [15:0] exp_bcd;
      logic        exp_tc, exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(logic r, logic c, logic l, logic [15:0] v, logic e, logic u,
                                logic [15:0] eb, logic et, logic ee);
      vec_t x;
      x.r = r; x.c = c; x.l = l; x.v = v; x.e = e; x.u = u;
      x.exp_bcd = eb; x.exp_tc = et; x.exp_err = ee;
      return x;
   endfunction

   initial begin
      int tc_cnt, tc_at;
      logic [15:0] rv;
      rst = 1; clr = 0; ld = 0; lv = '0; en = 0; up = 1;

      // Reset, then a full up walk with one wrap.
      tick(1, 0, 0, 16'h0, 0, 1);
      check("reset_bcd", 32'(bcd_w), 32'h0);
      check("reset_seg_d0", 32'(seg_w[6:0]), 32'h40);
      tc_cnt = 0; tc_at = -1;
      for (int i = 0; i < 10000; i++) begin
         tick(0, 0, 0, 16'h0, 1, 1);
         if (tc_w) begin tc_cnt++; tc_at = i; end
      end
      check("walk_tc_count", 32'(tc_cnt), 32'd1);
      check("walk_tc_cycle", 32'(tc_at), 32'd9999);
      check("walk_end", 32'(bcd_w), 32'h0);

      vecs.push_back(mkv(0, 0, 1, 16'h0100, 0, 1, 16'h0100, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 0, 16'h0099, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 16'h0000, 0, 1, 16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 0, 16'h9999, 1, 0));
      vecs.push_back(mkv(0, 0, 1, 16'h1A3F, 0, 1, 16'h1030, 0, 1));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 0, 1, 16'h1030, 0, 0));
      vecs.push_back(mkv(0, 1, 1, 16'h4321, 1, 1, 16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 16'h4321, 0, 1, 16'h4321, 0, 0));
      vecs.push_back(mkv(0, 0, 1, 16'h0456, 0, 1, 16'h0456, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 1, 16'h0457, 0, 0));
      vecs.push_back(mkv(1, 0, 1, 16'h1234, 1, 1, 16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0));
      vecs.push_back(mkv(0, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 0));
      foreach (vecs[i]) begin
         tick(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].v, vecs[i].e, vecs[i].u);
         check($sformatf("vec%0d_bcd", i), 32'(bcd_w), 32'(vecs[i].exp_bcd));
         check($sformatf("vec%0d_tc", i),  32'(tc_w),  32'(vecs[i].exp_tc));
         check($sformatf("vec%0d_err", i), 32'(err_w), 32'(vecs[i].exp_err));
      end

      // Invalid-digit load and its 7-segment view.
      tick(0, 0, 1, 16'h1A3F, 0, 1);
      check("ld_err_pulse", 32'(err_w), 32'd1);
      check("seg_d0_zero", 32'(seg_w[6:0]), 32'h40);
      check("seg_d3_one", 32'(seg_w[27:21]), 32'h79);
      tick(0, 0, 0, 16'h0, 0, 1);
      check("ld_err_gone", 32'(err_w), 32'd0);

      // Saturation at the top end.
      tick(0, 0, 1, 16'h9998, 0, 1);
      tick(0, 0, 0, 16'h0, 1, 1);
      check("sat_up1_bcd", 32'(bcd_s), 32'h9999);
      check("sat_up1_tc", 32'(tc_s), 32'd1);
      for (int i = 2; i <= 3; i++) begin
         tick(0, 0, 0, 16'h0, 1, 1);
         check($sformatf("sat_up%0d_bcd", i), 32'(bcd_s), 32'h9999);
         check($sformatf("sat_up%0d_tc", i), 32'(tc_s), 32'd0);
      end
      tick(0, 0, 0, 16'h0, 1, 0);
      check("sat_down_bcd", 32'(bcd_s), 32'h9998);

      // Saturation at the bottom end.
      tick(0, 0, 1, 16'h0001, 0, 1);
      tick(0, 0, 0, 16'h0, 1, 0);
      check("sat_dn_tc", 32'(tc_s), 32'd1);
      tick(0, 0, 0, 16'h0, 1, 0);
      check("sat_dn_hold", 32'(bcd_s), 32'h0);
      check("sat_dn_tc2", 32'(tc_s), 32'd0);

      // Random traffic with loads near both ends.
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0: rv = 16'($urandom);
            1: rv = to_bcd(int'($urandom_range(9990, 9999)));
            2: rv = to_bcd(int'($urandom_range(0, 9)));
            default: rv = to_bcd(int'($urandom_range(0, 9999)));
         endcase
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 15) == 0), rv,
              ($urandom_range(0, 3) != 0), (($urandom_range(0, 7)) < 4));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised N-digit BCD up/down counter; next generation of the board's free-running decimal seconds counter.
- Adds count enable, direction, parallel load, synchronous clear, wrap/saturate mode, terminal-count pulse and an optional 7-segment bus.
- Sits between the clock-divider tick and the 7-segment display multiplexer.
- Each digit always holds a legal BCD value, 0-9.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1-8); counter range 0 to 10^NUM_DIGITS-1
WRAP_EN, 1, 1 = wrap at the range ends; 0 = saturate at the range ends
SEG_EN, 1, 1 = instantiate a per-digit 7-segment decoder; 0 = seg_out tied to all-ones (segments off)

Ports:
clk_in  input  1  system clock; all logic on the rising edge
reset_in  input  1  synchronous reset, active-high
count_en_in  input  1  one-cycle tick from the clock divider; count one step when high
up_down_in  input  1  1 = count up, 0 = count down; sampled with count_en_in
load_in  input  1  parallel load strobe
load_value_in  input  4*NUM_DIGITS  BCD load value; digit k at [4k+3:4k], digit 0 = ones
clear_in  input  1  synchronous clear to zero
bcd_out  output  4*NUM_DIGITS  registered BCD count
seg_out  output  7*NUM_DIGITS  7-segment pattern per digit; digit k at [7k+6:7k]
tc_out  output  1  one-cycle pulse when an end of range is crossed (wrap) or hit (saturate)
load_err_out  output  1  one-cycle pulse when load_value_in contains a digit above 9

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on reset_in.
- Reset values: bcd_out = 0, tc_out = 0, load_err_out = 0. seg_out shows all digits as "0" (SEG_EN = 1).
- Priority per cycle: reset_in > clear_in > load_in > count_en_in. Lower-priority requests in the same cycle are dropped, not queued.
- clear_in: bcd_out <= 0 next cycle; tc_out stays 0.
- load_in: each digit loads its field. Any field > 9 loads 0 for that digit only, and load_err_out pulses for one cycle.
- Count up, carry chain:
  - Digit k increments when count_en_in is high and all lower digits equal 9.
  - A digit at 9 that increments goes to 0.
  - Ripple is resolved within one cycle, so all digits update on the same edge.
- Count down, borrow chain:
  - Digit k decrements when all lower digits equal 0.
  - A digit at 0 that decrements goes to 9.
- Range ends, WRAP_EN = 1:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - tc_out pulses high in the cycle bcd_out shows the wrapped value.
- Range ends, WRAP_EN = 0:
  - Up at all-9s holds; down at all-0s holds.
  - tc_out pulses on the step that reaches the end value.
  - Further requests at the end value hold the count and do not pulse tc_out again.
  - A later opposite-direction step leaves the end normally.
- Latency:
  - Every request reaches bcd_out one cycle after the edge that samples it.
  - tc_out and load_err_out are registered and aligned with that bcd_out update.
- seg_out: combinational decode of the registered bcd_out, so it has no extra latency.
- count_en_in held high for several cycles counts one step per cycle; back-to-back ticks are legal.
- up_down_in changing between ticks takes effect on the next tick; no hidden state.
- Reset asserted mid-count or mid-load: the next edge forces the reset values; the pending load is discarded.

Decomposition:
- Package bcd_counter_pkg: BCD_MAX = 4'd9, BCD_ZERO = 4'd0, and the digit-width and segment-width constants (4, 7).
- Sub-module bcd_digit_cell, one per digit. Inputs: step, dir, load, load value, clear. Outputs: digit value, carry/borrow-propagate flag (digit at 9 going up, at 0 going down).
- Top-level tasks:
  - chain the propagate flags with a generate loop;
  - compute terminal count as the AND of all propagate flags;
  - apply WRAP_EN;
  - instantiate the existing 7-segment decoder per digit when SEG_EN = 1.

Test Plan:
1. Reset then 10000 up ticks (NUM_DIGITS = 4, WRAP_EN = 1) -> bcd_out walks 0000..9999 in legal BCD, then 0000. tc_out pulses exactly once, on the 0000 cycle.
2. Load 16'h0100, then one down tick -> bcd_out = 16'h0099 next cycle, tc_out = 0. Load 16'h0000, down tick -> 16'h9999 with tc_out = 1.
3. WRAP_EN = 0: load 16'h9998, then 3 up ticks -> 9999, 9999, 9999. tc_out pulses on the first tick only. Then one down tick -> 9998.
4. Load 16'h1A3F -> bcd_out = 16'h1030 and load_err_out = 1 for one cycle. seg_out digit 0 shows "0", digit 3 shows "1".
5. Same cycle: clear_in = 1, load_in = 1 (16'h4321), count_en_in = 1 -> bcd_out = 0000. Next cycle load_in alone -> 4321.
6. Count to 0457, then assert reset_in together with load_in and count_en_in -> next edge bcd_out = 0000, tc_out = 0, load_err_out = 0. Counting resumes from 0000 after release.
